alu_arb: RTL and testbench

ALU_ARB -- requirements
Module: alu_arb

---
 rtl/alu_arb_if.sv | 63 ++++++
 rtl/alu_arb.sv | 142 ++++++++++++++
 tb/tb_alu_arb.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arb_if.sv
// Bundle of requester, response and shared-ALU signals for the two-port ALU arbiter.
interface alu_arb_if #(
   parameter int unsigned DW  = 32,
   parameter int unsigned OPW = 5
);
   // Requester 0 / 1 operation channels
   logic           req0_valid;
   logic           req0_ready;
   logic [DW-1:0]  req0_a;
   logic [DW-1:0]  req0_b;
   logic [OPW-1:0] req0_op;
   logic [31:0]    req0_pc;

   logic           req1_valid;
   logic           req1_ready;
   logic [DW-1:0]  req1_a;
   logic [DW-1:0]  req1_b;
   logic [OPW-1:0] req1_op;
   logic [31:0]    req1_pc;

   // Result channels
   logic           resp0_valid;
   logic [DW-1:0]  resp0_c;
   logic           resp0_zero;

   logic           resp1_valid;
   logic [DW-1:0]  resp1_c;
   logic           resp1_zero;

   // Shared combinational ALU
   logic [DW-1:0]  alu_a;
   logic [DW-1:0]  alu_b;
   logic [OPW-1:0] alu_op;
   logic [31:0]    alu_pc;
   logic [DW-1:0]  alu_c;
   logic           alu_zero;

   logic           busy;

   // Arbiter side
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op, req0_pc,
      input  req1_valid, req1_a, req1_b, req1_op, req1_pc,
      output req0_ready, req1_ready,
      output resp0_valid, resp0_c, resp0_zero,
      output resp1_valid, resp1_c, resp1_zero,
      output alu_a, alu_b, alu_op, alu_pc,
      input  alu_c, alu_zero,
      output busy
   );

   // Requesters plus the ALU itself
   modport master (
      output req0_valid, req0_a, req0_b, req0_op, req0_pc,
      output req1_valid, req1_a, req1_b, req1_op, req1_pc,
      input  req0_ready, req1_ready,
      input  resp0_valid, resp0_c, resp0_zero,
      input  resp1_valid, resp1_c, resp1_zero,
      input  alu_a, alu_b, alu_op, alu_pc,
      output alu_c, alu_zero,
      input  busy
   );
endinterface

// File: rtl/alu_arb.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation per three cycles: IDLE (grant) -> EXEC (ALU evaluates) -> RESP (strobe).
module alu_arb #(
   parameter int unsigned DW  = 32,
   parameter int unsigned OPW = 5
) (
   input  logic      clk,
   input  logic      rstn,
   alu_arb_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [DW-1:0]  a;
      logic [DW-1:0]  b;
      logic [OPW-1:0] op;
      logic [31:0]    pc;
   } opnd_t;

   state_t         state_q, state_d;
   logic           last_q, last_d;      // last granted requester; also the owner of the op in flight
   opnd_t          cap_q, cap_d;
   logic [DW-1:0]  resp0_c_q, resp0_c_d;
   logic [DW-1:0]  resp1_c_q, resp1_c_d;
   logic           resp0_zero_q, resp0_zero_d;
   logic           resp1_zero_q, resp1_zero_d;

   logic           grant_c;
   logic           req0_ready_c, req1_ready_c;
   logic           resp0_valid_c, resp1_valid_c;
   logic           busy_c;
   opnd_t          alu_drv_c;

   // Grant selection: alternate on contention, otherwise take whoever is valid
   always_comb begin
      grant_c = bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) begin
         grant_c = ~last_q;
      end
   end

   // Next-state, capture and output decode
   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      cap_d         = cap_q;
      resp0_c_d     = resp0_c_q;
      resp1_c_d     = resp1_c_q;
      resp0_zero_d  = resp0_zero_q;
      resp1_zero_d  = resp1_zero_q;
      req0_ready_c  = 1'b0;
      req1_ready_c  = 1'b0;
      resp0_valid_c = 1'b0;
      resp1_valid_c = 1'b0;
      busy_c        = 1'b1;
      alu_drv_c     = cap_q;

      case (state_q)
         IDLE: begin
            busy_c    = 1'b0;
            alu_drv_c = '0;
            if (bus.req0_valid || bus.req1_valid) begin
               req0_ready_c = rstn & ~grant_c;
               req1_ready_c = rstn & grant_c;
               last_d       = grant_c;
               state_d      = EXEC;
               if (grant_c) begin
                  cap_d.a  = bus.req1_a;
                  cap_d.b  = bus.req1_b;
                  cap_d.op = bus.req1_op;
                  cap_d.pc = bus.req1_pc;
               end else begin
                  cap_d.a  = bus.req0_a;
                  cap_d.b  = bus.req0_b;
                  cap_d.op = bus.req0_op;
                  cap_d.pc = bus.req0_pc;
               end
            end
         end
         EXEC: begin
            if (last_q) begin
               resp1_c_d    = bus.alu_c;
               resp1_zero_d = bus.alu_zero;
            end else begin
               resp0_c_d    = bus.alu_c;
               resp0_zero_d = bus.alu_zero;
            end
            state_d = RESP;
         end
         RESP: begin
            resp0_valid_c = ~last_q;
            resp1_valid_c = last_q;
            state_d       = IDLE;
         end
         default: begin
            alu_drv_c = '0;
            state_d   = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         last_q       <= 1'b1;
         cap_q        <= '0;
         resp0_c_q    <= '0;
         resp1_c_q    <= '0;
         resp0_zero_q <= 1'b0;
         resp1_zero_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         cap_q        <= cap_d;
         resp0_c_q    <= resp0_c_d;
         resp1_c_q    <= resp1_c_d;
         resp0_zero_q <= resp0_zero_d;
         resp1_zero_q <= resp1_zero_d;
      end
   end

   assign bus.req0_ready  = req0_ready_c;
   assign bus.req1_ready  = req1_ready_c;
   assign bus.resp0_valid = resp0_valid_c;
   assign bus.resp1_valid = resp1_valid_c;
   assign bus.resp0_c     = resp0_c_q;
   assign bus.resp1_c     = resp1_c_q;
   assign bus.resp0_zero  = resp0_zero_q;
   assign bus.resp1_zero  = resp1_zero_q;
   assign bus.alu_a       = alu_drv_c.a;
   assign bus.alu_b       = alu_drv_c.b;
   assign bus.alu_op      = alu_drv_c.op;
   assign bus.alu_pc      = alu_drv_c.pc;
   assign bus.busy        = busy_c;

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb: directed scenarios plus randomized traffic
// compared against a transaction-level model of the arbiter.
module tb_alu_arb;

   localparam int unsigned DW  = 32;
   localparam int unsigned OPW = 5;

   localparam logic [4:0] OP_ADD   = 5'd0;
   localparam logic [4:0] OP_SUB   = 5'd1;
   localparam logic [4:0] OP_AUIPC = 5'd2;
   localparam logic [4:0] OP_AND   = 5'd3;
   localparam logic [4:0] OP_BAD   = 5'd19;

   logic clk;
   logic rstn;

   alu_arb_if #(.DW(DW), .OPW(OPW)) bus ();

   alu_arb #(.DW(DW), .OPW(OPW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Shared ALU behaviour as seen by the arbiter
   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] op, input logic [31:0] pc);
      case (op)
         OP_ADD:   return a + b;
         OP_SUB:   return a - b;
         OP_AUIPC: return pc + b;
         OP_AND:   return a & b;
         default:  return 32'hFFFF_FFFF;
      endcase
   endfunction

   always_comb begin
      bus.alu_c    = alu_f(bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_pc);
      bus.alu_zero = (bus.alu_c == 32'd0);
   end

   int checks = 0;
   int errors = 0;

   // Transaction-level model state
   int          cyc = 0;
   int          busy_until;
   bit          m_last;
   logic [31:0] m_a, m_b, m_pc;
   logic [4:0]  m_op;
   logic [31:0] m_c [2];
   bit          m_z [2];
   bit          p_vld;
   int          p_due;
   bit          p_g;
   logic [31:0] p_c;
   int          nresp [2];
   int          glog [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      busy_until = cyc - 10;
      m_last     = 1'b1;
      m_a = '0; m_b = '0; m_pc = '0; m_op = '0;
      m_c[0] = '0; m_c[1] = '0;
      m_z[0] = 1'b0; m_z[1] = 1'b0;
      p_vld = 1'b0;
   endtask

   task automatic set_req(input int i, input bit v, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
      if (i == 0) begin
         bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_pc = pc;
      end else begin
         bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_pc = pc;
      end
   endtask

   // One clock: check all outputs mid-cycle against the model, then advance the model.
   task automatic cycle();
      bit free, g, er0, er1, erv0, erv1;
      @(negedge clk);
      free = (cyc > busy_until);
      g    = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
      er0  = free && bus.req0_valid && !g;
      er1  = free && bus.req1_valid && g;
      erv0 = 1'b0;
      erv1 = 1'b0;
      if (p_vld && p_due == cyc) begin
         m_c[p_g] = p_c;
         m_z[p_g] = (p_c == 32'd0);
         if (p_g) erv1 = 1'b1; else erv0 = 1'b1;
         p_vld = 1'b0;
      end
      chk("ready0", 64'(bus.req0_ready), 64'(er0));
      chk("ready1", 64'(bus.req1_ready), 64'(er1));
      chk("resp0_valid", 64'(bus.resp0_valid), 64'(erv0));
      chk("resp1_valid", 64'(bus.resp1_valid), 64'(erv1));
      chk("resp0_c", 64'(bus.resp0_c), 64'(m_c[0]));
      chk("resp1_c", 64'(bus.resp1_c), 64'(m_c[1]));
      chk("resp0_zero", 64'(bus.resp0_zero), 64'(m_z[0]));
      chk("resp1_zero", 64'(bus.resp1_zero), 64'(m_z[1]));
      chk("busy", 64'(bus.busy), 64'(!free));
      chk("alu_a", 64'(bus.alu_a), free ? 64'd0 : 64'(m_a));
      chk("alu_b", 64'(bus.alu_b), free ? 64'd0 : 64'(m_b));
      chk("alu_op", 64'(bus.alu_op), free ? 64'd0 : 64'(m_op));
      chk("alu_pc", 64'(bus.alu_pc), free ? 64'd0 : 64'(m_pc));
      if (bus.resp0_valid) nresp[0]++;
      if (bus.resp1_valid) nresp[1]++;
      @(posedge clk);
      if (er0 || er1) begin
         m_last = g;
         if (g) begin
            m_a = bus.req1_a; m_b = bus.req1_b; m_op = bus.req1_op; m_pc = bus.req1_pc;
         end else begin
            m_a = bus.req0_a; m_b = bus.req0_b; m_op = bus.req0_op; m_pc = bus.req0_pc;
         end
         busy_until = cyc + 2;
         p_vld      = 1'b1;
         p_due      = cyc + 2;
         p_g        = g;
         p_c        = alu_f(m_a, m_b, m_op, m_pc);
         glog.push_back(int'(g));
      end
      cyc++;
      #1;
   endtask

   // Asynchronous reset pulse with immediate output checks; valids are left as the caller set them.
   task automatic do_reset();
      #1;
      rstn = 1'b0;
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_ready0", 64'(bus.req0_ready), 64'd0);
      chk("rst_ready1", 64'(bus.req1_ready), 64'd0);
      chk("rst_resp0_valid", 64'(bus.resp0_valid), 64'd0);
      chk("rst_resp1_valid", 64'(bus.resp1_valid), 64'd0);
      chk("rst_resp0_c", 64'(bus.resp0_c), 64'd0);
      chk("rst_resp1_c", 64'(bus.resp1_c), 64'd0);
      chk("rst_resp0_zero", 64'(bus.resp0_zero), 64'd0);
      chk("rst_alu_a", 64'(bus.alu_a), 64'd0);
      chk("rst_alu_op", 64'(bus.alu_op), 64'd0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, s0, s1;
      rstn = 1'b0;
      set_req(0, 1'b0, '0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0, '0);
      model_reset();

      // Reset state with a requester already asserting valid
      set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1, 32'd0);
      do_reset();
      set_req(0, 1'b0, '0, '0, '0, '0);
      repeat (2) cycle();

      // Single add on requester 0: ready at T, result at T+2
      set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7, 32'd0);
      #1 chk("add_ready0_T", 64'(bus.req0_ready), 64'd1);
      cycle();
      set_req(0, 1'b0, '0, '0, '0, '0);
      cycle();
      chk("add_resp0_valid", 64'(bus.resp0_valid), 64'd1);
      chk("add_resp0_c", 64'(bus.resp0_c), 64'd12);
      chk("add_resp0_zero", 64'(bus.resp0_zero), 64'd0);
      chk("add_resp1_valid", 64'(bus.resp1_valid), 64'd0);
      repeat (2) cycle();

      // Simultaneous requests after reset: requester 0 first
      do_reset();
      set_req(0, 1'b1, OP_SUB, 32'd9, 32'd9, 32'd0);
      set_req(1, 1'b1, OP_ADD, 32'd1, 32'd2, 32'd0);
      #1 chk("both_ready0", 64'(bus.req0_ready), 64'd1);
      chk("both_ready1", 64'(bus.req1_ready), 64'd0);
      cycle();
      set_req(0, 1'b0, '0, '0, '0, '0);
      cycle();
      chk("sub_resp0_c", 64'(bus.resp0_c), 64'd0);
      chk("sub_resp0_zero", 64'(bus.resp0_zero), 64'd1);
      chk("sub_resp0_valid", 64'(bus.resp0_valid), 64'd1);
      repeat (3) cycle();
      chk("add1_resp1_valid", 64'(bus.resp1_valid), 64'd1);
      chk("add1_resp1_c", 64'(bus.resp1_c), 64'd3);
      chk("add1_resp1_zero", 64'(bus.resp1_zero), 64'd0);
      set_req(1, 1'b0, '0, '0, '0, '0);
      repeat (2) cycle();

      // Both held valid for 12 cycles: alternating grants, two responses each
      do_reset();
      n0 = glog.size();
      s0 = nresp[0];
      s1 = nresp[1];
      set_req(0, 1'b1, OP_ADD, 32'd10, 32'd20, 32'd0);
      set_req(1, 1'b1, OP_AND, 32'hF0F0, 32'h0FF0, 32'd0);
      repeat (12) cycle();
      set_req(0, 1'b0, '0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0, '0);
      chk("rr_grant_count", 64'(glog.size() - n0), 64'd4);
      if (glog.size() >= n0 + 4) begin
         chk("rr_grant0", 64'(glog[n0]), 64'd0);
         chk("rr_grant1", 64'(glog[n0+1]), 64'd1);
         chk("rr_grant2", 64'(glog[n0+2]), 64'd0);
         chk("rr_grant3", 64'(glog[n0+3]), 64'd1);
      end
      chk("rr_resp0_count", 64'(nresp[0] - s0), 64'd2);
      chk("rr_resp1_count", 64'(nresp[1] - s1), 64'd2);
      repeat (3) cycle();

      // auipc on requester 1
      set_req(1, 1'b1, OP_AUIPC, 32'hDEAD, 32'h1000, 32'h80);
      cycle();
      set_req(1, 1'b0, '0, '0, '0, '0);
      cycle();
      chk("auipc_resp1_valid", 64'(bus.resp1_valid), 64'd1);
      chk("auipc_resp1_c", 64'(bus.resp1_c), 64'h1080);
      repeat (2) cycle();

      // Reset in the middle of EXEC aborts the operation
      set_req(0, 1'b1, OP_ADD, 32'd3, 32'd4, 32'd0);
      cycle();
      chk("exec_busy", 64'(bus.busy), 64'd1);
      set_req(0, 1'b0, '0, '0, '0, '0);
      do_reset();
      s0 = nresp[0];
      repeat (4) cycle();
      chk("abort_no_resp0", 64'(nresp[0] - s0), 64'd0);
      set_req(0, 1'b1, OP_ADD, 32'd3, 32'd4, 32'd0);
      cycle();
      set_req(0, 1'b0, '0, '0, '0, '0);
      cycle();
      chk("post_abort_resp0_valid", 64'(bus.resp0_valid), 64'd1);
      chk("post_abort_resp0_c", 64'(bus.resp0_c), 64'd7);
      repeat (2) cycle();

      // Unassigned opcode passes the ALU default value through
      set_req(0, 1'b1, OP_BAD, 32'd1, 32'd2, 32'd0);
      cycle();
      set_req(0, 1'b0, '0, '0, '0, '0);
      cycle();
      chk("badop_resp0_valid", 64'(bus.resp0_valid), 64'd1);
      chk("badop_resp0_c", 64'(bus.resp0_c), 64'hFFFF_FFFF);
      repeat (2) cycle();

      // Randomized traffic, valids that come and go, occasional resets
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < 2; i++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            case ($urandom_range(0, 4))
               0:       op = OP_ADD;
               1:       op = OP_SUB;
               2:       op = OP_AUIPC;
               3:       op = OP_AND;
               default: op = 5'($urandom_range(4, 31));
            endcase
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            set_req(i, ($urandom_range(0, 2) != 0), op, a, b, $urandom);
         end
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
         end
         cycle();
      end
      set_req(0, 1'b0, '0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0, '0);
      repeat (4) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
